// File: rtl/demux_1ton_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_1ton_stream
//  Description : Registered 1-to-N stream demultiplexer with valid/ready
//                handshake. Each word goes to the channel chosen by in_sel,
//                or to every channel when in_bcast is set. Every channel owns
//                a one-entry output register, so a stalled consumer only
//                blocks traffic aimed at its own channel. Words addressed to
//                a non-existent channel are accepted, discarded and counted
//                in a saturating drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_1ton_stream #(
   parameter int WIDTH = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]   in_sel,
   input  logic               in_bcast,
   output logic [N-1:0]       out_valid,
   input  logic [N-1:0]       out_ready,
   output logic [N*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]   drop_cnt
);

   // All-ones value at which the drop counter stops counting.
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   logic             r_valid [N];
   logic [WIDTH-1:0] r_data  [N];
   logic [CNT_W-1:0] r_drop_cnt;

   logic [N-1:0]     w_sel_hit;   // one-hot decode of in_sel (all zero when out of range)
   logic [N-1:0]     w_can_acc;   // slot is free now or is being drained this cycle
   logic [N-1:0]     w_load;      // slot captures in_data at the next edge
   logic             w_in_range;
   logic             w_xfer;
   logic             w_drop;

   // Channel decode, slot acceptance and per-slot registers.
   generate
      for (genvar k = 0; k < N; k++) begin : g_chan
         // The extra top bit keeps the compare exact for any SEL_W/N pairing.
         assign w_sel_hit[k] = ({1'b0, in_sel} == (SEL_W+1)'(k));
         assign w_can_acc[k] = ~r_valid[k] | out_ready[k];
         assign w_load[k]    = w_xfer & (in_bcast | w_sel_hit[k]);
         assign out_valid[k] = r_valid[k];
         assign out_data[k*WIDTH +: WIDTH] = r_data[k];

         // Slot register: a load wins over a drain, so drain+load keeps the
         // slot full with the new word; data is left untouched when idle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid[k] <= 1'b0;
               r_data[k]  <= '0;
            end else if (w_load[k]) begin
               r_valid[k] <= 1'b1;
               r_data[k]  <= in_data;
            end else if (out_ready[k]) begin
               r_valid[k] <= 1'b0;
            end
         end
      end
   endgenerate

   assign w_in_range = |w_sel_hit;

   // Ready depends only on slot state, out_ready and the routing fields, never
   // on in_valid. Broadcast is all-or-nothing; out-of-range words always go.
   always_comb begin
      in_ready = 1'b1;
      if (in_bcast) begin
         in_ready = &w_can_acc;
      end else if (w_in_range) begin
         in_ready = |(w_sel_hit & w_can_acc);
      end
   end

   assign w_xfer = in_valid & in_ready;
   assign w_drop = w_xfer & ~in_bcast & ~w_in_range;

   // Saturating count of words discarded for an out-of-range channel index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drop_cnt <= '0;
      end else if (w_drop && (r_drop_cnt != c_CNT_MAX)) begin
         r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_1ton_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_1ton_stream
//  Description : Self-checking bench for demux_1ton_stream. A queue-based
//                model of each channel predicts ready, valid, data and the
//                drop count every cycle; directed sequences pin the model
//                with literal expectations, then random traffic follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_1ton_stream;

   localparam int WIDTH = 32;
   localparam int N     = 4;
   localparam int SEL_W = 3;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data;
   logic [SEL_W-1:0]   in_sel;
   logic               in_bcast;
   logic [N-1:0]       out_valid;
   logic [N-1:0]       out_ready;
   logic [N*WIDTH-1:0] out_data;
   logic [CNT_W-1:0]   drop_cnt;

   demux_1ton_stream #(
      .WIDTH(WIDTH), .N(N), .SEL_W(SEL_W), .CNT_W(CNT_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_bcast (in_bcast),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .drop_cnt (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each channel is a FIFO of words not yet consumed; last_d remembers the
   // most recent word delivered to the channel (what an idle channel shows).
   logic [WIDTH-1:0] mq [N][$];
   logic [WIDTH-1:0] last_d [N];
   int               m_cnt;
   bit               m_acc;

   function automatic bit model_ready();
      bit all_ok = 1'b1;
      for (int k = 0; k < N; k++)
         if (!(mq[k].size() == 0 || out_ready[k])) all_ok = 1'b0;
      if (in_bcast) return all_ok;
      if (int'(in_sel) < N) return (mq[in_sel].size() == 0) || out_ready[in_sel];
      return 1'b1;
   endfunction

   // Model update at each active edge (or immediately on reset).
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) begin
            mq[k].delete();
            last_d[k] = '0;
         end
         m_cnt = 0;
      end else begin
         m_acc = in_valid && model_ready();
         for (int k = 0; k < N; k++)
            if (mq[k].size() > 0 && out_ready[k]) void'(mq[k].pop_front());
         if (m_acc) begin
            if (in_bcast) begin
               for (int k = 0; k < N; k++) begin
                  mq[k].push_back(in_data);
                  last_d[k] = in_data;
               end
            end else if (int'(in_sel) < N) begin
               mq[in_sel].push_back(in_data);
               last_d[in_sel] = in_data;
            end else if (m_cnt < CNT_MAX) begin
               m_cnt++;
            end
         end
      end
   end

   // Compare process: every falling edge while out of reset.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         check("in_ready", 64'(in_ready), 64'(model_ready()));
         for (int k = 0; k < N; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(mq[k].size() != 0));
            check($sformatf("out_data[%0d]", k), 64'(out_data[k*WIDTH +: WIDTH]),
                  64'((mq[k].size() != 0) ? mq[k][0] : last_d[k]));
         end
         check("drop_cnt", 64'(drop_cnt), 64'(m_cnt));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] chan(input int k);
      return out_data[k*WIDTH +: WIDTH];
   endfunction

   logic [WIDTH-1:0] uni_words [4];
   int               exp_drop  [5];

   initial begin
      uni_words = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000, 32'hD000_0000};
      exp_drop  = '{1, 2, 3, 3, 3};
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0;
      in_bcast = 1'b0; out_ready = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset mid-stream with ch1 holding a word.
      in_valid = 1'b1; in_sel = 3'd1; in_data = 32'hA000_0000; out_ready = 4'b0000;
      tick();
      in_valid = 1'b0;
      #1;
      check("pre_rst_valid", 64'(out_valid), 64'h2);
      check("pre_rst_data1", 64'(chan(1)), 64'hA000_0000);
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_valid", 64'(out_valid), 64'h0);
      check("rst_data", 64'(out_data), 64'h0);
      check("rst_drop", 64'(drop_cnt), 64'h0);
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      for (int s = 0; s < 4; s++) begin
         in_sel = 3'(s);
         #1 check($sformatf("idle_ready_sel%0d", s), 64'(in_ready), 64'h1);
      end

      // Unicast routing, back-to-back.
      out_ready = 4'hF;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_bcast = 1'b0; in_sel = 3'(i); in_data = uni_words[i];
         #1 check($sformatf("uni_ready%0d", i), 64'(in_ready), 64'h1);
         tick();
         check($sformatf("uni_valid%0d", i), 64'(out_valid), 64'(1 << i));
         check($sformatf("uni_data%0d", i), 64'(chan(i)), 64'(uni_words[i]));
      end

      // Backpressure on ch2.
      out_ready = 4'b1011;
      in_sel = 3'd2; in_data = 32'h1111_1111;
      tick();
      in_data = 32'h2222_2222;
      #1 check("bp_ready_lo", 64'(in_ready), 64'h0);
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'h4);
      check("bp_hold_data", 64'(chan(2)), 64'h1111_1111);
      out_ready = 4'hF;
      #1 check("bp_ready_hi", 64'(in_ready), 64'h1);
      tick();
      check("bp_second", 64'(chan(2)), 64'h2222_2222);
      out_ready = 4'b1011;
      in_sel = 3'd0; in_data = 32'h3333_3333;
      #1 check("bp_other_ready", 64'(in_ready), 64'h1);
      tick();
      check("bp_other_valid", 64'(out_valid), 64'h5);
      check("bp_other_data", 64'(chan(0)), 64'h3333_3333);

      // Broadcast blocked by full ch2, then released.
      in_bcast = 1'b1; in_data = 32'hBCBC_0001;
      #1 check("bc_ready_lo", 64'(in_ready), 64'h0);
      tick();
      check("bc_noload_valid", 64'(out_valid), 64'h4);
      check("bc_noload_d0", 64'(chan(0)), 64'h3333_3333);
      out_ready = 4'hF;
      #1 check("bc_ready_hi", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0; in_bcast = 1'b0;
      check("bc_valid", 64'(out_valid), 64'hF);
      for (int k = 0; k < N; k++)
         check($sformatf("bc_data%0d", k), 64'(chan(k)), 64'hBCBC_0001);
      tick();

      // Drop counter saturation.
      in_valid = 1'b1; in_sel = 3'd5; in_data = 32'hDEAD_0000;
      for (int i = 0; i < 5; i++) begin
         #1 check($sformatf("drop_ready%0d", i), 64'(in_ready), 64'h1);
         tick();
         check($sformatf("drop_cnt%0d", i), 64'(drop_cnt), 64'(exp_drop[i]));
         check($sformatf("drop_valid%0d", i), 64'(out_valid), 64'h0);
      end

      // Simultaneous drain and load on ch3.
      in_sel = 3'd3; in_data = 32'h0000_00AA;
      tick();
      check("dl_first", 64'(chan(3)), 64'h0000_00AA);
      in_data = 32'h0000_00BB;
      #1 check("dl_ready", 64'(in_ready), 64'h1);
      tick();
      check("dl_valid", 64'(out_valid), 64'h8);
      check("dl_data", 64'(chan(3)), 64'h0000_00BB);
      in_valid = 1'b0;
      tick();

      // Randomised traffic, with one reset pulse in the middle.
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst_n = 1'b0;
            #1 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_bcast  = 1'($urandom_range(0, 7) == 0);
         in_sel    = 3'($urandom_range(0, 7));
         in_data   = $urandom;
         out_ready = 4'($urandom);
         tick();
      end
      in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/demux_1ton_stream.md
Name: demux_1toN_stream

Overview:
Parametrised registered 1-to-N stream demultiplexer with valid/ready handshake, and the successor of the combinational 1-to-2 demux. Routes each input word to the output channel chosen by in_sel, or to all channels in broadcast mode. Each channel has a one-entry output register, so a stalled consumer does not corrupt other channels. Sits between a single producer and N independent consumers, for example a fan-out to N processing lanes.

Parameters:
- WIDTH, 32, data word width in bits.
- N, 4, number of output channels (range 2..16).
- SEL_W, 2, width of in_sel; must satisfy 2**SEL_W >= N.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle; combinational.
- in_data  input  WIDTH  input word.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = broadcast to all channels; in_sel is ignored.
- out_valid  output  N  per-channel valid; bit k is channel k.
- out_ready  input  N  per-channel consumer ready.
- out_data  output  N*WIDTH  channel k occupies out_data[k*WIDTH +: WIDTH].
- drop_cnt  output  CNT_W  count of words dropped for out-of-range in_sel; saturates.

Behaviour:
- Reset (rst_n=0, asynchronous assert): out_valid=0, out_data=0, drop_cnt=0. Buffered words are discarded. Release is sampled on the next clk edge.
- Per-channel slot state v[k]=out_valid[k]. Define can_acc[k] = !v[k] | out_ready[k].
- in_ready, unicast mode (in_bcast=0):
  - in_sel<N: in_ready = can_acc[in_sel].
  - in_sel>=N: in_ready = 1.
- in_ready, broadcast mode (in_bcast=1): in_ready = AND of can_acc[0..N-1]. All-or-nothing: there are no partial broadcast writes.
- Transfer condition: in_valid & in_ready.
- Unicast transfer, in_sel<N: slot in_sel loads in_data, and its out_valid is set at the next edge. Latency is 1 cycle.
- Unicast transfer, in_sel>=N: the word is dropped. No slot changes. drop_cnt increments by 1 and holds at 2**CNT_W-1.
- Broadcast transfer: every slot loads in_data, and all out_valid bits become 1 next edge.
- Channel drain: out_valid[k] & out_ready[k] with no load to k clears v[k] next edge.
- Drain and load to the same channel in the same cycle: v[k] stays 1 and out_data[k] takes the new word. This gives full throughput of one word per cycle per channel.
- Stability: while out_valid[k] & !out_ready[k], out_data[k] is held unchanged.
- Data on an idle channel: out_data[k] keeps its last loaded value when v[k]=0. It is not cleared except by reset.
- Ordering: words to the same channel are delivered in input order. Channels are fully independent otherwise.
- in_valid=0: no state change other than drains. in_ready is still driven per the rules above.
- The ready path is combinational from out_ready to in_ready. There is no combinational path from in_valid to in_ready.

Test Plan:
- Reset and idle: assert rst_n=0 mid-stream with ch1 holding 32'hA000_0000. Required: out_valid=4'b0000, out_data=0 and drop_cnt=0 immediately. After release, in_ready=1 for any in_sel<4.
- Unicast routing: out_ready=4'hF; send 32'hA000_0000 sel=0, 32'hB000_0000 sel=1, 32'hC000_0000 sel=2, 32'hD000_0000 sel=3 back-to-back. Required: each appears one cycle later only on its own channel, with out_valid one-hot, and in_ready stays 1.
- Backpressure: out_ready[2]=0; send 32'h1111_1111 then 32'h2222_2222 both with sel=2. Required: the first word is held on ch2, and in_ready=0 for the second. Raise out_ready[2]: the second word is accepted that cycle and shown the next cycle. A concurrent sel=0 word still passes.
- Broadcast: out_ready=4'b1011 with ch2 full; send 32'hBCBC_0001 with in_bcast=1. Required: in_ready=0 and no channel is loaded. Once ch2 drains, all four channels show 32'hBCBC_0001 simultaneously.
- Drop counter: N=4, SEL_W=3, CNT_W=2; send 5 words with sel=5. Required: in_ready=1 each time, no out_valid asserted, and drop_cnt goes 1,2,3,3,3 (saturates).
- Simultaneous drain and load: ch3 valid with 32'h0000_00AA and out_ready[3]=1, while 32'h0000_00BB with sel=3 is sent. Required: out_valid[3] stays 1 and out_data[3]=32'h0000_00BB next cycle.
